// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared constants and the reference approximate-product function
package approx_mul_pkg;
   localparam int   N_STAGES    = 3;
   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;
   // Number of pair-vector slots; at least one so zero approximated rows still yield a legal bus
   function automatic int pair_slots(input int l);
      return (l / 2 > 0) ? l / 2 : 1;
   endfunction
   // Approximate product: exact high rows plus OR-merged, truncated low row pairs
   function automatic logic [31:0] approx_mul(input logic [15:0] a, input logic [15:0] b, input int l, input int t);
      logic [31:0] r;
      logic [31:0] bb;
      bb = {16'd0, b};
      r  = (({16'd0, a} >> l) * bb) << l;
      for (int k = 0; k < l; k += 2)
         r = r + ((((bb & {32{a[k]}}) << k) | ((bb & {32{a[k+1]}}) << (k + 1))) & (32'hFFFF_FFFF << t));
      return r;
   endfunction
endpackage

// File: rtl/approx_mul_pipe_compress.sv
// approx_pp_compress: OR-merges adjacent approximated multiplier rows into pair vectors, truncated below column T
module approx_pp_compress
   import approx_mul_pkg::*;
#(
   parameter int W = 8,
   parameter int L = 4,
   parameter int T = 6
) (
   input  logic [W-1:0]                      x,
   input  logic [W-1:0]                      y,
   output logic [pair_slots(L)*2*W-1:0]      pv
);
   localparam int PW = 2 * W;
   localparam logic [PW-1:0] KEEP = {PW{1'b1}} << T;
   // One slot per row pair; unused slots stay zero
   always_comb begin
      pv = '0;
      for (int k = 0; k < L / 2; k++)
         pv[k*PW +: PW] = (((PW'(y) & {PW{x[2*k]}}) << (2 * k)) | ((PW'(y) & {PW{x[2*k+1]}}) << (2 * k + 1))) & KEEP;
   end
endmodule

// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: 3-stage exact/approximate unsigned multiplier with valid/ready flow control.
// Define APPROX_MUL_PIPE_ERRSTAT_EN to add the err output and err_sum/op_cnt statistics.
module approx_mul_pipe
   import approx_mul_pkg::*;
#(
   parameter int W = 8,
   parameter int L = 4,
   parameter int T = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   input  logic           mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] z
`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
   ,
   output logic [2*W-1:0] err,
   output logic [31:0]    err_sum,
   output logic [31:0]    op_cnt
`endif
);
   localparam int PW = 2 * W;
   localparam int NP = pair_slots(L);
   logic             stall;
   logic [NP*PW-1:0] pv;
   logic [PW-1:0]    hi, ex, asum;
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic             m1_q, m1_d;
   logic [W-1:0]     x1_q, x1_d, y1_q, y1_d;
   logic [NP*PW-1:0] pv1_q, pv1_d;
   logic [PW-1:0]    hi2_q, hi2_d, as2_q, as2_d, z_q, z_d;

   approx_pp_compress #(.W(W), .L(L), .T(T)) u_compress (
      .x  (x),
      .y  (y),
      .pv (pv)
   );

   assign stall     = v3_q & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v3_q;
   assign z         = z_q;

   // Next state of every stage; the whole pipe freezes while the output is stalled
   always_comb begin
      asum = '0;
      for (int k = 0; k < L / 2; k++)
         asum = asum + pv1_q[k*PW +: PW];
      hi    = ((PW'(x1_q) >> L) * PW'(y1_q)) << L;
      ex    = PW'(x1_q) * PW'(y1_q);
      v1_d  = stall ? v1_q : in_valid;
      x1_d  = stall ? x1_q : x;
      y1_d  = stall ? y1_q : y;
      m1_d  = stall ? m1_q : mode;
      pv1_d = stall ? pv1_q : pv;
      v2_d  = stall ? v2_q : v1_q;
      hi2_d = stall ? hi2_q : (m1_q == MODE_APPROX) ? hi : ex;
      as2_d = stall ? as2_q : (m1_q == MODE_APPROX) ? asum : '0;
      v3_d  = stall ? v3_q : v2_q;
      z_d   = stall ? z_q : hi2_q + as2_q;
   end

   // Stage registers; reset discards anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q  <= 1'b0;
         x1_q  <= '0;
         y1_q  <= '0;
         m1_q  <= 1'b0;
         pv1_q <= '0;
         v2_q  <= 1'b0;
         hi2_q <= '0;
         as2_q <= '0;
         v3_q  <= 1'b0;
         z_q   <= '0;
      end else begin
         v1_q  <= v1_d;
         x1_q  <= x1_d;
         y1_q  <= y1_d;
         m1_q  <= m1_d;
         pv1_q <= pv1_d;
         v2_q  <= v2_d;
         hi2_q <= hi2_d;
         as2_q <= as2_d;
         v3_q  <= v3_d;
         z_q   <= z_d;
      end
   end

`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
   logic          m2_q, m2_d, m3_q, m3_d, take;
   logic [PW-1:0] ex2_q, ex2_d, ex3_q, ex3_d;
   logic [31:0]   err_sum_q, err_sum_d, op_cnt_q, op_cnt_d;
   logic [32:0]   es_sum;

   assign err     = ex3_q - z_q;
   assign err_sum = err_sum_q;
   assign op_cnt  = op_cnt_q;

   // Carry mode and exact product beside the datapath; accumulate saturating statistics per consumed result
   always_comb begin
      m2_d      = stall ? m2_q : m1_q;
      m3_d      = stall ? m3_q : m2_q;
      ex2_d     = stall ? ex2_q : ex;
      ex3_d     = stall ? ex3_q : ex2_q;
      take      = v3_q & out_ready;
      es_sum    = {1'b0, err_sum_q} + 33'(err);
      err_sum_d = !take ? err_sum_q : es_sum[32] ? '1 : es_sum[31:0];
      op_cnt_d  = (take && m3_q == MODE_APPROX && op_cnt_q != '1) ? op_cnt_q + 32'd1 : op_cnt_q;
   end

   // Statistics registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m2_q      <= 1'b0;
         m3_q      <= 1'b0;
         ex2_q     <= '0;
         ex3_q     <= '0;
         err_sum_q <= '0;
         op_cnt_q  <= '0;
      end else begin
         m2_q      <= m2_d;
         m3_q      <= m3_d;
         ex2_q     <= ex2_d;
         ex3_q     <= ex3_d;
         err_sum_q <= err_sum_d;
         op_cnt_q  <= op_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb_approx_mul_pipe: directed and streaming checks of approx_mul_pipe at W=8, L=4, T=6
module tb_approx_mul_pipe;
   import approx_mul_pkg::*;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, mode, out_valid, out_ready;
   logic [7:0]  x, y;
   logic [15:0] z;
   int          cmp = 0;
   int          errs = 0;
`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
   logic [15:0] err;
   logic [31:0] err_sum, op_cnt;
`endif

   approx_mul_pipe #(.W(8), .L(4), .T(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z)
`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
      ,
      .err       (err),
      .err_sum   (err_sum),
      .op_cnt    (op_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic md);
      logic [31:0] r;
      r = (md == MODE_APPROX) ? approx_mul({8'd0, a}, {8'd0, b}, 4, 6) : 32'(a) * 32'(b);
      return r[15:0];
   endfunction

   task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic md, input logic [15:0] exp, input string nm);
      in_valid = 1'b1; x = a; y = b; mode = md;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      cmp++;
      if (out_valid !== 1'b0) begin
         errs++;
         $display("FAIL %s_early: out_valid=%b want 0", nm, out_valid);
      end
      @(posedge clk); #1;
      cmp++;
      if (out_valid !== 1'b1 || z !== exp) begin
         errs++;
         $display("FAIL %s: out_valid=%b z=%h want 1 z=%h", nm, out_valid, z, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; mode = 1'b0; out_ready = 1'b1;
      #3;
      cmp++;
      if (out_valid !== 1'b0 || z !== 16'h0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL reset_state: out_valid=%b z=%h in_ready=%b want 0 0000 1", out_valid, z, in_ready);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_one(8'h03, 8'h05, 1'b0, 16'h000F, "first_after_reset");
   endtask

   task automatic test_directed();
      run_one(8'hFF, 8'hFF, 1'b1, 16'hF890, "ff_ff_approx");
      run_one(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ff_ff_exact");
      run_one(8'h0F, 8'h01, 1'b1, 16'h0000, "0f_01_approx");
      run_one(8'h0F, 8'h01, 1'b0, 16'h000F, "0f_01_exact");
      run_one(8'h10, 8'h10, 1'b1, 16'h0100, "10_10_approx");
      run_one(8'h03, 8'hFF, 1'b1, 16'h01C0, "03_ff_approx");
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_q [100];
      int bad = 0;
      for (int c = 0; c < 103; c++) begin
         @(posedge clk); #1;
         cmp++;
         if (out_valid !== (c >= 3)) begin
            bad++;
            errs++;
            $display("FAIL b2b_valid[%0d]: out_valid=%b want %b", c, out_valid, c >= 3);
         end else if (c >= 3 && z !== exp_q[c-3]) begin
            bad++;
            errs++;
            $display("FAIL b2b_data[%0d]: z=%h want %h", c - 3, z, exp_q[c-3]);
         end
         if (c < 100) begin
            in_valid = 1'b1;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            mode = 1'($urandom_range(0, 1));
            exp_q[c] = model(x, y, mode);
         end else begin
            in_valid = 1'b0;
         end
         if (bad > 5) break;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_stall();
      logic [15:0] q [$];
      int seen = 0;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b1; x = 8'hFF; y = 8'hFF; mode = 1'b1;
      @(posedge clk); #1;
      x = 8'h0F; y = 8'h0F; mode = 1'b0;
      @(posedge clk); #1;
      x = 8'h03; y = 8'hFF; mode = 1'b1;
      @(posedge clk); #1;
      x = 8'h12; y = 8'h34; mode = 1'b0;
      q = '{16'h00E1, 16'h01C0, 16'h03A8};
      for (int i = 0; i < 5; i++) begin
         cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== 16'hF890) begin
            errs++;
            $display("FAIL stall_hold[%0d]: in_ready=%b out_valid=%b z=%h want 0 1 f890", i, in_ready, out_valid, z);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            seen++;
            cmp++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL stall_extra: z=%h want no result", z);
            end else if (z !== q[0]) begin
               errs++;
               $display("FAIL stall_order: z=%h want %h", z, q[0]);
            end
            if (q.size() != 0) void'(q.pop_front());
         end
      end
      cmp++;
      if (seen != 3) begin
         errs++;
         $display("FAIL stall_count: got %0d results want 3", seen);
      end
   endtask

   task automatic test_reset_inflight();
      in_valid = 1'b1; x = 8'hFF; y = 8'hFF; mode = 1'b1;
      @(posedge clk); #1;
      x = 8'h0F; y = 8'h01; mode = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      cmp++;
      if (out_valid !== 1'b1) begin
         errs++;
         $display("FAIL rst_pre: out_valid=%b want 1", out_valid);
      end
      #1 rst = 1'b1;
      #1;
      cmp++;
      if (out_valid !== 1'b0 || z !== 16'h0) begin
         errs++;
         $display("FAIL rst_async: out_valid=%b z=%h want 0 0000", out_valid, z);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         cmp++;
         if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_stale[%0d]: out_valid=%b want 0", i, out_valid);
         end
      end
   endtask

`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
   task automatic test_errstat();
      run_one(8'hFF, 8'hFF, 1'b1, 16'hF890, "err_case");
      cmp++;
      if (err !== 16'd1393 || op_cnt !== 32'd0) begin
         errs++;
         $display("FAIL err_value: err=%0d op_cnt=%0d want 1393 0", err, op_cnt);
      end
      @(posedge clk); #1;
      cmp++;
      if (op_cnt !== 32'd1 || err_sum !== 32'd1393) begin
         errs++;
         $display("FAIL err_count: op_cnt=%0d err_sum=%0d want 1 1393", op_cnt, err_sum);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef APPROX_MUL_PIPE_ERRSTAT_EN
      test_errstat();
`endif
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule

// File: doc/approx_mul_pipe.md
APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 SHALL have parameter W, default 8: operand width, 4..16.
REQ-002 SHALL have parameter L, default 4: number of approximated low multiplier rows; even, 0..W.
REQ-003 SHALL have parameter T, default 6: truncation column; approximated-row bits in columns below T are dropped; 0..2W.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1): input handshake.
REQ-007 SHALL have ports x and y, input, W bits: unsigned operands.
REQ-008 SHALL have port mode, input, 1 bit: 1 = approximate, 0 = exact; sampled with the operands.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1): output handshake.
REQ-010 SHALL have port z, output, 2W bits: product.

Function
REQ-011 SHALL compute, in exact mode, z = x*y exactly.
REQ-012 SHALL compute, in approximate mode, z = (y*x[W-1:L] << L) + sum over pairs k=0,2,..,L-2 of P_k.
- P_k = bitwise OR of (y & {W{x[k]}}) << k and (y & {W{x[k+1]}}) << (k+1), with columns < T forced to 0.
- All additions are exact, in 2W bits, with no overflow possible.
REQ-013 SHALL reduce, when L=0, approximate mode to exact mode.
REQ-014 SHALL be a 3-stage pipeline:
- S1: register operands, mode, and the OR-compressed pair vectors.
- S2: register the high partial product and the summed approximate vectors.
- S3: register the final sum into z.
REQ-015 SHALL have a latency of 3 cycles from an accepted input (in_valid & in_ready) to out_valid with no backpressure.
REQ-016 SHALL sustain a throughput of one result per cycle when out_ready is held 1.
REQ-017 SHALL define stall = out_valid & ~out_ready; during stall all stages SHALL hold and in_ready SHALL be 0.
REQ-018 SHALL drive in_ready = ~stall, combinationally.
REQ-019 SHALL hold z and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL let bubbles (in_valid=0) propagate as stage-valid 0; an empty stage SHALL never cause a stall.
REQ-021 SHALL capture a new input on the same cycle a result is consumed with no dead cycle.
REQ-022 SHALL hold per-stage valid bits; data registers of invalid stages may hold stale values but out_valid SHALL be 0 for them.

Reset
REQ-023 SHALL, on rst asserted, asynchronously clear all stage valid bits, out_valid and z to 0.
REQ-024 SHALL drive in_ready=1 while rst=0 and the pipe is not stalled; results in flight when reset asserts mid-operation SHALL be discarded and never emitted.
REQ-025 SHALL release from reset synchronously to clk; the first input may be accepted on the first edge after release.

Configuration
REQ-026 SHALL use the macro APPROX_MUL_PIPE_ERRSTAT_EN.
- Defined: adds output err (2W bits) = exact product minus z, aligned with z, and counters err_sum (32 bits, saturating sum of err) and op_cnt (32 bits, saturating count of approximate-mode results consumed), both cleared by rst.
- Undefined: these ports and this logic are absent, with no other behavioural change.
REQ-027 SHALL make err non-negative, because every approximation only drops or OR-merges bits.

Structure
REQ-028 SHALL place in shared package approx_mul_pkg: the stage-count constant (3), the mode encoding constants, and a function that computes the approximate product, which the bench reuses as the reference model.
REQ-029 SHALL use one sub-module, approx_pp_compress: combinational generation of the OR-pair vectors for S1, parameterised by W, L, T.

Verification (W=8, L=4, T=6)
REQ-030 SHALL cover: x=0xFF, y=0xFF, mode=1 -> z=0xF890 (63632) after 3 cycles; mode=0 -> z=0xFE01.
REQ-031 SHALL cover: x=0x0F, y=0x01, mode=1 -> z=0x0000; mode=0 -> z=0x000F.
REQ-032 SHALL cover: back-to-back 100 random inputs with out_ready=1 -> 100 results in order, 1 per cycle, each matching the package model.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with 3 results in flight -> in_ready=0, z stable, no loss or duplication after release.
REQ-034 SHALL cover: rst asserted with 2 results in flight -> out_valid=0 immediately, no stale result after release.
REQ-035 SHALL cover, with ERRSTAT_EN defined: the 0xFF*0xFF approximate case -> err=1393, and op_cnt increments by 1 on consumption.
